// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Moore FSM control unit for a multicycle MIPS-subset datapath.
//               Sequences fetch/decode/execute/memory/writeback, stretches
//               memory accesses with mem_ready, counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic               ir_we,
  output logic               reg_we,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_ctrl,
  output logic               illegal,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   instr_count
);

  // Shared ALU operation codes
  localparam logic [2:0] c_alu_and = 3'b000;
  localparam logic [2:0] c_alu_or  = 3'b001;
  localparam logic [2:0] c_alu_add = 3'b010;
  localparam logic [2:0] c_alu_off = 3'b011;
  localparam logic [2:0] c_alu_sub = 3'b110;
  localparam logic [2:0] c_alu_slt = 3'b111;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = STATE_W'(0),
    S_DECODE    = STATE_W'(1),
    S_MEM_ADDR  = STATE_W'(2),
    S_MEM_READ  = STATE_W'(3),
    S_MEM_WB    = STATE_W'(4),
    S_MEM_WRITE = STATE_W'(5),
    S_EXECUTE   = STATE_W'(6),
    S_R_WB      = STATE_W'(7),
    S_BRANCH    = STATE_W'(8),
    S_ADDI_EXEC = STATE_W'(9),
    S_ADDI_WB   = STATE_W'(10),
    S_JUMP      = STATE_W'(11)
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             retire_d;
  logic             funct_ok;
  logic [2:0]       funct_alu;

  // R-type funct decode: legality for DECODE, ALU operation for EXECUTE
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = c_alu_off;
    case (funct)
      c_fn_add: funct_alu = c_alu_add;
      c_fn_sub: funct_alu = c_alu_sub;
      c_fn_and: funct_alu = c_alu_and;
      c_fn_or:  funct_alu = c_alu_or;
      c_fn_slt: funct_alu = c_alu_slt;
      default:  funct_ok  = 1'b0;
    endcase
  end

  // Next-state selection; retire_d marks a completed instruction returning to FETCH
  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          c_op_rtype:      state_d = funct_ok ? S_EXECUTE : S_FETCH;
          c_op_lw, c_op_sw: state_d = S_MEM_ADDR;
          c_op_beq:        state_d = S_BRANCH;
          c_op_addi:       state_d = S_ADDI_EXEC;
          c_op_j:          state_d = S_JUMP;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == c_op_sw) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    begin state_d = S_FETCH; retire_d = 1'b1; end
      S_MEM_WRITE: if (mem_ready) begin state_d = S_FETCH; retire_d = 1'b1; end
      S_EXECUTE:   state_d = S_R_WB;
      S_R_WB:      begin state_d = S_FETCH; retire_d = 1'b1; end
      S_BRANCH:    begin state_d = S_FETCH; retire_d = 1'b1; end
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   begin state_d = S_FETCH; retire_d = 1'b1; end
      S_JUMP:      begin state_d = S_FETCH; retire_d = 1'b1; end
      default:     state_d = S_FETCH;
    endcase
  end

  // State and retired-instruction counter; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_d) count_q <= count_q + CNT_W'(1);
    end
  end

  // Moore output decode of the current state, forced quiet while reset is held
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_ctrl   = c_alu_off;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_ctrl  = c_alu_add;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_ctrl  = c_alu_add;
          illegal   = (state_d == S_FETCH);
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = c_alu_add;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_we     = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_ctrl  = funct_alu;
        end
        S_R_WB: begin
          reg_dst = 1'b1;
          reg_we  = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_ctrl  = c_alu_sub;
          pc_src    = 2'b01;
          pc_we     = zero;
        end
        S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = c_alu_add;
        end
        S_ADDI_WB: reg_we = 1'b1;
        S_JUMP: begin
          pc_src = 2'b10;
          pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Scoreboard bench for multicycle_ctrl. Stimulus expands each
//               instruction into its expected per-cycle control trace and
//               queues it; a monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_OFF = 3'b011;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_SLT = 3'b111;

  typedef struct packed {
    logic [3:0]  st;
    logic        pc_we, ir_we, reg_we, mem_read, mem_write, iord, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_src;
    logic [2:0]  alu_ctrl;
    logic        illegal;
    logic [15:0] cnt;
  } exp_t;

  logic        clk, rst_n, zero, mem_ready;
  logic [5:0]  opcode, funct;
  logic        pc_we, ir_we, reg_we, mem_read, mem_write, iord, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state;
  logic [15:0] instr_count;

  // Narrow-counter instance sharing the stimulus, to exercise counter wrap
  logic        s_pc_we, s_ir_we, s_reg_we, s_mem_read, s_mem_write, s_iord, s_reg_dst, s_mem_to_reg, s_alu_src_a, s_illegal;
  logic [1:0]  s_alu_src_b, s_pc_src;
  logic [2:0]  s_alu_ctrl;
  logic [3:0]  s_state;
  logic [3:0]  s_count;

  exp_t        q[$];
  exp_t        aq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_cnt    = '0;
  bit          done     = 1'b0;
  logic [5:0]  legal_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  multicycle_ctrl #(.STATE_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctrl(alu_ctrl), .illegal(illegal),
    .state(state), .instr_count(instr_count)
  );

  multicycle_ctrl #(.STATE_W(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_we(s_pc_we), .ir_we(s_ir_we), .reg_we(s_reg_we), .mem_read(s_mem_read), .mem_write(s_mem_write),
    .iord(s_iord), .reg_dst(s_reg_dst), .mem_to_reg(s_mem_to_reg), .alu_src_a(s_alu_src_a),
    .alu_src_b(s_alu_src_b), .pc_src(s_pc_src), .alu_ctrl(s_alu_ctrl), .illegal(s_illegal),
    .state(s_state), .instr_count(s_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // {legal, alu code} for an R-type funct
  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return {1'b1, A_ADD};
      6'h22:   return {1'b1, A_SUB};
      6'h24:   return {1'b1, A_AND};
      6'h25:   return {1'b1, A_OR};
      6'h2A:   return {1'b1, A_SLT};
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected record for a state with every control at its default
  function automatic exp_t base(input logic [3:0] st);
    exp_t e;
    e          = '0;
    e.st       = st;
    e.alu_ctrl = A_OFF;
    e.cnt      = m_cnt;
    return e;
  endfunction

  // One clock cycle: apply inputs, queue the expected output, advance
  task automatic cyc(input exp_t e, input logic mr, input logic z);
    mem_ready = mr;
    zero      = z;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Expand one instruction into its expected cycle-by-cycle trace
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw, input int abort_at);
    exp_t       e;
    logic       mr;
    logic [3:0] ra;
    logic       legal;
    opcode = op;
    funct  = fn;
    ra     = r_alu(fn);
    for (int i = 0; i <= fw; i++) begin
      mr = (i == fw);
      e = base(4'd0); e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_ctrl = A_ADD;
      e.ir_we = mr; e.pc_we = mr;
      cyc(e, mr, rb());
    end
    legal = (op == 6'h00 && ra[3]) || (op inside {6'h23, 6'h2B, 6'h04, 6'h08, 6'h02});
    e = base(4'd1); e.alu_src_b = 2'b11; e.alu_ctrl = A_ADD; e.illegal = !legal;
    cyc(e, rb(), rb());
    if (!legal) return;
    case (op)
      6'h00: begin
        e = base(4'd6); e.alu_src_a = 1'b1; e.alu_ctrl = ra[2:0]; cyc(e, rb(), rb());
        e = base(4'd7); e.reg_dst = 1'b1; e.reg_we = 1'b1;         cyc(e, rb(), rb());
      end
      6'h23: begin
        e = base(4'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = A_ADD; cyc(e, rb(), rb());
        for (int i = 0; i <= mw; i++) begin
          mr = (i == mw);
          e = base(4'd3); e.mem_read = 1'b1; e.iord = 1'b1; cyc(e, mr, rb());
        end
        e = base(4'd4); e.mem_to_reg = 1'b1; e.reg_we = 1'b1; cyc(e, rb(), rb());
      end
      6'h2B: begin
        e = base(4'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = A_ADD; cyc(e, rb(), rb());
        for (int i = 0; i <= mw; i++) begin
          if (i == abort_at) begin
            m_cnt = '0;
            aq.push_back(base(4'd0));
            rst_n = 1'b0;
            cyc(base(4'd0), 1'b1, 1'b0);
            rst_n = 1'b1;
            return;
          end
          mr = (i == mw);
          e = base(4'd5); e.mem_write = 1'b1; e.iord = 1'b1; cyc(e, mr, rb());
        end
      end
      6'h04: begin
        e = base(4'd8); e.alu_src_a = 1'b1; e.alu_ctrl = A_SUB; e.pc_src = 2'b01; e.pc_we = z;
        cyc(e, rb(), z);
      end
      6'h08: begin
        e = base(4'd9); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = A_ADD; cyc(e, rb(), rb());
        e = base(4'd10); e.reg_we = 1'b1; cyc(e, rb(), rb());
      end
      default: begin
        e = base(4'd11); e.pc_src = 2'b10; e.pc_we = 1'b1; cyc(e, rb(), rb());
      end
    endcase
    m_cnt = m_cnt + 16'd1;
  endtask

  // Compare one expected record against the live outputs of both instances
  task automatic compare(input exp_t e, input string tag);
    exp_t a;
    a.st = state; a.pc_we = pc_we; a.ir_we = ir_we; a.reg_we = reg_we;
    a.mem_read = mem_read; a.mem_write = mem_write; a.iord = iord; a.reg_dst = reg_dst;
    a.mem_to_reg = mem_to_reg; a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b;
    a.pc_src = pc_src; a.alu_ctrl = alu_ctrl; a.illegal = illegal; a.cnt = instr_count;
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s #%0d: actual=%h required=%h", tag, n_checks, a, e);
    end
    n_checks++;
    if (s_count !== e.cnt[3:0]) begin
      n_fail++;
      $display("FAIL wrap_count #%0d: actual=%h required=%h", n_checks, s_count, e.cnt[3:0]);
    end
  endtask

  // Monitor: per-cycle trace checks at the falling edge, immediate checks on async reset
  initial begin : monitor
    while (!done) begin
      @(negedge clk or negedge rst_n);
      #1;
      if (aq.size() > 0) compare(aq.pop_front(), "async_reset");
      if (clk == 1'b0 && q.size() > 0) compare(q.pop_front(), "cycle");
    end
    n_checks++;
    if (q.size() != 0 || aq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual=%0d pending required=0", q.size() + aq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Stimulus
  initial begin : stim
    rst_n = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
    #2;
    m_cnt = '0;
    aq.push_back(base(4'd0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc(base(4'd0), 1'b1, 1'b0);
    cyc(base(4'd0), 1'b1, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_instr(6'h00, legal_fn[4 - i], 1'b0, 0, 0, -1);
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, -1);
    run_instr(6'h23, 6'h00, 1'b0, 2, 0, -1);
    run_instr(6'h2B, 6'h00, 1'b0, 0, 0, -1);
    run_instr(6'h2B, 6'h00, 1'b0, 1, 2, -1);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, -1);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, -1);
    run_instr(6'h08, 6'h11, 1'b0, 0, 0, -1);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, -1);
    run_instr(6'h3F, 6'h20, 1'b0, 0, 0, -1);
    run_instr(6'h00, 6'h01, 1'b0, 0, 0, -1);
    run_instr(6'h2B, 6'h00, 1'b0, 0, 4, 2);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, -1);

    for (int k = 0; k < 60; k++) begin
      int         sel;
      logic [5:0] op;
      logic [5:0] fn;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: op = 6'h00;
        3:       op = 6'h23;
        4:       op = 6'h2B;
        5:       op = 6'h04;
        6:       op = 6'h08;
        7:       op = 6'h02;
        8:       op = 6'h3F;
        default: op = 6'($urandom);
      endcase
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
      run_instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0 && aq.size() == 0) break;
      @(posedge clk);
    end
    done = 1'b1;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the 32-bit MIPS-subset datapath. A Moore FSM sequences fetch, decode, execute, memory and writeback for each instruction. It drives the 3-bit `alu_ctrl` of the ALU directly upstream of it, consumes that ALU's `zero` flag for branches, and generates every datapath enable and mux select. Memory accesses are stretched by a `mem_ready` handshake.

## Interface
- `STATE_W`, default 4: state register width.
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `opcode` input 6: instruction bits [31:26]; stable from the end of FETCH.
- `funct` input 6: instruction bits [5:0].
- `zero` input 1: ALU zero flag (combinational).
- `mem_ready` input 1: memory has completed the current access this cycle.
- `pc_we`, `ir_we`, `reg_we`, `mem_read`, `mem_write` output 1 each: enables.
- `iord` output 1: memory address select (0 = PC, 1 = ALUOut).
- `reg_dst` output 1: destination register (0 = rt, 1 = rd).
- `mem_to_reg` output 1: writeback data (0 = ALUOut, 1 = MDR).
- `alu_src_a` output 1: ALU A operand (0 = PC, 1 = A register).
- `alu_src_b` output 2: ALU B operand (00 = B register, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2).
- `pc_src` output 2: next PC (00 = ALU result, 01 = ALUOut, 10 = jump target).
- `alu_ctrl` output 3: shared ALU codes `AND`/`OR`/`ADD`/`SUB`/`SLT`/`OFF` from the constants header.
- `illegal` output 1: one-cycle pulse on an unsupported instruction.
- `state` output STATE_W: current state, for debug.
- `instr_count` output CNT_W: number of instructions retired.

## Operation
State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, ADDI_EXEC=9, ADDI_WB=10, JUMP=11.

Default outputs: all enables 0, all selects 0, `alu_ctrl`=`OFF`. Each state lists only the outputs that differ from the defaults.

- FETCH: mem_read=1, alu_src_b=01, alu_ctrl=ADD, ir_we=pc_we=mem_ready. Goes to DECODE when mem_ready=1, otherwise holds.
- DECODE: alu_src_b=11, alu_ctrl=ADD (precomputes the branch target). Next state by opcode:
  - 000000 with a legal funct → EXECUTE
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDI_EXEC
  - 000010 (j) → JUMP
  - anything else → FETCH with illegal=1
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, iord=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: mem_to_reg=1, reg_we=1. Then FETCH.
- MEM_WRITE: mem_write=1, iord=1. Holds until mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT). Then R_WB.
  - Any other funct is illegal; it is caught in DECODE and never reaches EXECUTE.
- R_WB: reg_dst=1, reg_we=1. Then FETCH.
- BRANCH: alu_src_a=1, SUB, pc_src=01, pc_we=zero. Then FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, ADD. Then ADDI_WB, which sets reg_we=1 and then goes to FETCH.
- JUMP: pc_src=10, pc_we=1. Then FETCH.

`instr_count` increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH (taken or not), ADDI_WB or JUMP. It does not increment on an illegal return. It wraps modulo 2^CNT_W.

## Timing
- Reset, asynchronous: state=FETCH and instr_count=0 immediately on rst_n falling.
  - While rst_n=0, all enables and illegal are 0 and alu_ctrl=OFF, regardless of mem_ready.
  - First FETCH outputs appear when rst_n=1.
  - Reset mid-instruction abandons the instruction and issues no writes.
- Outputs are combinational decode of the registered state. pc_we in BRANCH also depends on zero; ir_we/pc_we in FETCH also depend on mem_ready.
- Minimum cycles per instruction, with mem_ready tied to 1:
  - lw 5, sw 4
  - R-type 4, addi 4
  - beq 3, j 3
  - illegal 2
- Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle. The access strobes stay asserted while waiting.
- mem_ready is ignored in every other state.
- zero is sampled only during BRANCH.

## Test plan
- Reset: rst_n=0 with mem_ready=1 → all enables 0, alu_ctrl=OFF, state=0. Release → FETCH with mem_read=1, pc_we=ir_we=1, alu_ctrl=ADD.
- R-type, mem_ready=1:
  - opcode=000000, funct=101010 → states 0,1,6,7,0; alu_ctrl=SLT in EXECUTE; reg_we=1, reg_dst=1 in R_WB; instr_count +1.
  - Repeat for funct 100000, 100010, 100100, 100101 → alu_ctrl ADD, SUB, AND, OR in EXECUTE.
- lw with mem_ready low for 3 cycles in MEM_READ → MEM_READ lasts 4 cycles with mem_read=iord=1 throughout; total 8 cycles; mem_to_reg=1 in MEM_WB.
- beq:
  - zero=1 → pc_we=1, pc_src=01 in BRANCH.
  - zero=0 → pc_we=0.
  - Both retire, instr_count +1 each.
- opcode=111111, or opcode=000000 with funct=000001 → illegal pulses for 1 cycle in DECODE; back to FETCH; instr_count unchanged; no reg_we or mem_write.
- Async reset asserted mid-stream:
  - During MEM_WRITE → mem_write drops immediately; state=0; count=0.
  - Separately, preload the count to 0xFFFF → the next retire wraps it to 0x0000.
